// File: rtl/match_ctrl.sv
// rtl/match_ctrl.sv - match sequencer gating the physics frame-start pulse
// Keeps scores, inserts the serve pause, declares match end and counts dropped ticks.
module match_ctrl #(
  parameter int SCORE_W      = 4,
  parameter int WIN_SCORE    = 15,
  parameter int PAUSE_FRAMES = 60
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick_60hz,
  input  logic               start_btn,
  input  logic               phys_valid,
  input  logic               phys_game_over,
  input  logic [1:0]         phys_winner,
  output logic               phys_en,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score,
  output logic               match_over,
  output logic [1:0]         match_winner,
  output logic               pausing,
  output logic [7:0]         overrun_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PLAY,
    S_POINT_WAIT,
    S_MATCH_OVER
  } state_t;

  localparam logic [SCORE_W-1:0] WIN_S      = SCORE_W'(WIN_SCORE);
  localparam logic [7:0]         PAUSE_INIT = 8'(PAUSE_FRAMES);

  state_t             state_q, state_d;
  logic               busy_q, busy_d;
  logic [7:0]         pause_cnt_q, pause_cnt_d;
  logic [SCORE_W-1:0] p1_q, p1_d;
  logic [SCORE_W-1:0] p2_q, p2_d;
  logic [1:0]         winner_q, winner_d;
  logic [7:0]         overrun_q, overrun_d;
  logic               phys_en_q, phys_en_d;
  logic               match_over_q, match_over_d;
  logic               pausing_q, pausing_d;

  logic               tick_free;
  logic               frame_done;
  logic               overrun_inc;
  logic [SCORE_W-1:0] new_score;

  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    pause_cnt_d  = pause_cnt_q;
    p1_d         = p1_q;
    p2_d         = p2_q;
    winner_d     = winner_q;
    overrun_d    = overrun_q;
    phys_en_d    = 1'b0;
    overrun_inc  = 1'b0;
    new_score    = '0;

    // A completion in the same cycle frees the slot before the tick is judged
    tick_free  = !busy_q || phys_valid;
    frame_done = phys_valid && busy_q;

    if (phys_valid) begin
      busy_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (start_btn) begin
          state_d = S_PLAY;
        end
      end

      S_PLAY: begin
        if (tick_60hz) begin
          if (tick_free) begin
            phys_en_d = 1'b1;
          end else begin
            overrun_inc = 1'b1;
          end
        end
        if (frame_done && phys_game_over &&
            (phys_winner == 2'd1 || phys_winner == 2'd2)) begin
          if (phys_winner == 2'd1) begin
            new_score = p1_q + 1'b1;
            p1_d      = new_score;
          end else begin
            new_score = p2_q + 1'b1;
            p2_d      = new_score;
          end
          if (new_score == WIN_S) begin
            winner_d = phys_winner;
            state_d  = S_MATCH_OVER;
          end else begin
            pause_cnt_d = PAUSE_INIT;
            state_d     = S_POINT_WAIT;
          end
        end
      end

      S_POINT_WAIT: begin
        if (tick_60hz) begin
          // Last pause tick launches the reset frame; a busy slot holds it at 1
          if (pause_cnt_q == 8'd1) begin
            if (tick_free) begin
              phys_en_d   = 1'b1;
              pause_cnt_d = 8'd0;
              state_d     = S_PLAY;
            end else begin
              overrun_inc = 1'b1;
            end
          end else if (pause_cnt_q != 8'd0) begin
            pause_cnt_d = pause_cnt_q - 8'd1;
          end
        end
      end

      S_MATCH_OVER: begin
        if (start_btn) begin
          p1_d        = '0;
          p2_d        = '0;
          winner_d    = 2'd0;
          pause_cnt_d = PAUSE_INIT;
          state_d     = S_POINT_WAIT;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (phys_en_d) begin
      busy_d = 1'b1;
    end
    if (overrun_inc && overrun_q != 8'hFF) begin
      overrun_d = overrun_q + 8'd1;
    end

    match_over_d = (state_d == S_MATCH_OVER);
    pausing_d    = (state_d == S_POINT_WAIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      busy_q       <= 1'b0;
      pause_cnt_q  <= 8'd0;
      p1_q         <= '0;
      p2_q         <= '0;
      winner_q     <= 2'd0;
      overrun_q    <= 8'd0;
      phys_en_q    <= 1'b0;
      match_over_q <= 1'b0;
      pausing_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      pause_cnt_q  <= pause_cnt_d;
      p1_q         <= p1_d;
      p2_q         <= p2_d;
      winner_q     <= winner_d;
      overrun_q    <= overrun_d;
      phys_en_q    <= phys_en_d;
      match_over_q <= match_over_d;
      pausing_q    <= pausing_d;
    end
  end

  assign phys_en      = phys_en_q;
  assign p1_score     = p1_q;
  assign p2_score     = p2_q;
  assign match_over   = match_over_q;
  assign match_winner = winner_q;
  assign pausing      = pausing_q;
  assign overrun_cnt  = overrun_q;

endmodule
